replica_sequencer: RTL

- Per-replica control FSM for the parallel-tempering salesman engine, sitting directly upstream of the replica unit.
- Generates the whole command stream the replica consumes each annealing iteration:
  - random-generator init and run strobes, plus the opt move type;
  - distance-delta phase, metropolis judge phase and ordering-apply phase;
  - periodic neighbour-replica swap phases with bank toggling.
- Counts iterations and reports completion to the host-side control.

---
 rtl/replica_pkg.sv | 29 ++
 rtl/phase_timer.sv | 26 ++
 rtl/replica_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/replica_pkg.sv
// Shared types for the replica sequencer: FSM states, command codes and opt-mode encodings.
package replica_pkg;

    typedef enum logic [2:0] {IDLE, INIT, OPT, DIST, METRO, APPLY, SWAP, DONE} state_t;

    typedef enum logic {OPT_TWO = 1'b0, OPT_OR = 1'b1} opt_command_t;

    typedef enum logic [1:0] {DIST_NOP = 2'd0, DIST_CALC = 2'd1} distance_command_t;

    typedef enum logic [2:0] {
        EX_NOP    = 3'd0,
        MET_JUDGE = 3'd1,
        MET_SWAP  = 3'd2,
        EX_APPLY  = 3'd3,
        EX_SWAP   = 3'd4
    } exchange_command_t;

    localparam logic [1:0] MODE_TWO     = 2'd0;
    localparam logic [1:0] MODE_OR      = 2'd1;
    localparam logic [1:0] MODE_ALT_OR  = 2'd2;
    localparam logic [1:0] MODE_ALT_TWO = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; last is high while the count sits at zero.
module phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign last = (count == '0);

endmodule

// File: rtl/replica_sequencer.sv
// Per-replica command sequencer: init/opt/distance/metropolis/apply phases per iteration,
// with periodic neighbour swaps and iteration accounting.
module replica_sequencer
    import replica_pkg::*;
#(
    parameter int CITY_NUM = 30,
    parameter int DIST_LAT = 4,
    parameter int MET_LAT  = 3,
    parameter int ITER_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] n_iter,
    input  logic [15:0]       exch_interval,
    input  logic [1:0]        opt_mode,
    input  logic [63:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              random_init,
    output logic [63:0]       random_seed,
    output logic              random_run,
    output opt_command_t      opt_command,
    output distance_command_t c_distance,
    output exchange_command_t c_metropolis,
    output exchange_command_t c_exchange,
    output logic              rbank,
    output logic              exch_parity
);

    localparam int PH_MAX = max3(CITY_NUM + 1, DIST_LAT, MET_LAT);
    localparam int PH_W   = ($clog2(PH_MAX) < 1) ? 1 : $clog2(PH_MAX);

    state_t            state;
    logic [ITER_W-1:0] n_iter_q;
    logic [15:0]       exch_q;
    logic              alt_q;
    opt_command_t      opt_sel;
    logic [ITER_W-1:0] iter_next;

    logic              ph_load, ph_last;
    logic [PH_W-1:0]   ph_val;
    logic              sw_load, sw_dec, sw_last;
    logic [15:0]       sw_val;

    assign iter_next = (&iter_count) ? iter_count : iter_count + 1'b1;

    // Timer is loaded with (length-1) on the cycle before each timed phase begins.
    always_comb begin
        ph_load = 1'b0;
        ph_val  = '0;
        case (state)
            OPT:     begin ph_load = 1'b1; ph_val = PH_W'(DIST_LAT - 1); end
            DIST:    if (ph_last) begin ph_load = 1'b1; ph_val = PH_W'(MET_LAT - 1); end
            METRO:   if (ph_last) begin ph_load = 1'b1; ph_val = PH_W'(CITY_NUM - 1); end
            APPLY:   if (ph_last) begin ph_load = 1'b1; ph_val = PH_W'(CITY_NUM); end
            default: ;
        endcase
    end

    // Swap counter holds (interval-1); a swap is due when it is already zero at iteration end.
    assign sw_load = !abort && ((state == IDLE && start) || (state == SWAP && ph_last));
    assign sw_val  = ((state == IDLE) ? exch_interval : exch_q) - 16'd1;
    assign sw_dec  = !abort && state == APPLY && ph_last && exch_q != '0;

    phase_timer #(.W(PH_W)) u_phase (
        .clk(clk), .reset(reset), .load(ph_load), .load_val(ph_val), .dec(1'b1), .last(ph_last)
    );

    phase_timer #(.W(16)) u_swap (
        .clk(clk), .reset(reset), .load(sw_load), .load_val(sw_val), .dec(sw_dec), .last(sw_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            n_iter_q     <= '0;
            exch_q       <= '0;
            alt_q        <= 1'b0;
            opt_sel      <= OPT_TWO;
            busy         <= 1'b0;
            done         <= 1'b0;
            iter_count   <= '0;
            random_init  <= 1'b0;
            random_seed  <= '0;
            random_run   <= 1'b0;
            opt_command  <= OPT_TWO;
            c_distance   <= DIST_NOP;
            c_metropolis <= EX_NOP;
            c_exchange   <= EX_NOP;
            rbank        <= 1'b0;
            exch_parity  <= 1'b0;
        end else begin
            done         <= 1'b0;
            random_init  <= 1'b0;
            random_run   <= 1'b0;
            c_distance   <= DIST_NOP;
            c_metropolis <= EX_NOP;
            c_exchange   <= EX_NOP;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        n_iter_q    <= n_iter;
                        exch_q      <= exch_interval;
                        random_seed <= seed;
                        alt_q       <= opt_mode[1];
                        opt_sel     <= (opt_mode == MODE_OR || opt_mode == MODE_ALT_OR) ? OPT_OR : OPT_TWO;
                        iter_count  <= '0;
                        if (n_iter == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= INIT;
                            busy        <= 1'b1;
                            random_init <= 1'b1;
                        end
                    end
                    INIT: begin
                        state       <= OPT;
                        random_run  <= 1'b1;
                        opt_command <= opt_sel;
                        if (alt_q) opt_sel <= opt_command_t'(~opt_sel);
                    end
                    OPT: begin
                        state      <= DIST;
                        c_distance <= DIST_CALC;
                    end
                    DIST: begin
                        if (ph_last) begin
                            state        <= METRO;
                            c_metropolis <= MET_JUDGE;
                        end else
                            c_distance <= DIST_CALC;
                    end
                    METRO: begin
                        if (ph_last) begin
                            state      <= APPLY;
                            c_exchange <= EX_APPLY;
                        end else
                            c_metropolis <= MET_JUDGE;
                    end
                    APPLY: begin
                        if (!ph_last)
                            c_exchange <= EX_APPLY;
                        else begin
                            iter_count <= iter_next;
                            if (iter_next == n_iter_q) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (exch_q != '0 && sw_last) begin
                                state        <= SWAP;
                                c_metropolis <= MET_SWAP;
                            end else begin
                                state       <= OPT;
                                random_run  <= 1'b1;
                                opt_command <= opt_sel;
                                if (alt_q) opt_sel <= opt_command_t'(~opt_sel);
                            end
                        end
                    end
                    SWAP: begin
                        if (!ph_last)
                            c_exchange <= EX_SWAP;
                        else begin
                            rbank       <= ~rbank;
                            exch_parity <= ~exch_parity;
                            state       <= OPT;
                            random_run  <= 1'b1;
                            opt_command <= opt_sel;
                            if (alt_q) opt_sel <= opt_command_t'(~opt_sel);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
